// File: rtl/output_fifo_reader.sv
// Drains W-bit pixels from the output FIFO and packs them into WORD_W-bit words
// for CSR readout; each word is held until acknowledged, and a short tail word is flushed.
//
// state   | meaning
// IDLE    | waiting for start after reset
// FILL    | popping pixels into the pack buffer, at most one pop in flight
// PRESENT | word_data valid, holding until word_ack
// DONE    | frame finished, done held until the next start
module output_fifo_reader #(
  parameter int W      = 8,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 20,
  localparam int LANES = WORD_W / W,
  localparam int LW    = $clog2(LANES) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [W-1:0]      fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              fifo_avail,
  input  logic              start,
  input  logic [CNT_W-1:0]  total,
  output logic [WORD_W-1:0] word_data,
  output logic [LW-1:0]     word_lanes,
  output logic              word_valid,
  input  logic              word_ack,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;

  localparam logic [LW-1:0] LANES_L = LW'(LANES);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [LW-1:0]    lane;
  logic             in_flight;
  logic [CNT_W-1:0] rem_next;
  logic [LW-1:0]    lane_next;

  // Counters as they will stand once the pixel returning this cycle is stored.
  always_comb begin
    rem_next  = remaining;
    lane_next = lane;
    if (in_flight) begin
      rem_next  = remaining - CNT_W'(1);
      lane_next = lane + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      remaining  <= '0;
      lane       <= '0;
      in_flight  <= 1'b0;
      fifo_rd_en <= 1'b0;
      word_data  <= '0;
      word_lanes <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      in_flight  <= fifo_rd_en;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (total == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= FILL;
              busy       <= 1'b1;
              done       <= 1'b0;
              remaining  <= total;
              lane       <= '0;
              word_data  <= '0;
              fifo_rd_en <= fifo_avail;
            end
          end
        end
        FILL: begin
          if (in_flight) begin
            for (int i = 0; i < LANES; i++) begin
              if (lane == LW'(i)) word_data[i*W +: W] <= fifo_rd_data;
            end
            remaining <= rem_next;
            lane      <= lane_next;
          end
          if (in_flight && (lane_next == LANES_L || rem_next == '0)) begin
            state      <= PRESENT;
            word_valid <= 1'b1;
            word_lanes <= lane_next;
          end else if (fifo_avail && !fifo_rd_en && rem_next != '0 && lane_next < LANES_L) begin
            // A pop may issue on the same edge the previous pixel lands.
            fifo_rd_en <= 1'b1;
          end
        end
        PRESENT: begin
          if (word_ack) begin
            word_valid <= 1'b0;
            word_data  <= '0;
            word_lanes <= '0;
            lane       <= '0;
            if (remaining == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
